// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the front end.
package cpu_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clear the low bits so every fetch address is instruction aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries between memory and decode.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 96,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // The fetch credit scheme upstream must never let an entry arrive with no room.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush))
    else $error("fetch_fifo: push while full");

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues sequential fetches under a buffer credit limit and
// discards in-flight responses that belong to the path abandoned by a redirect.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign redirect_target = align_pc(redirect_pc);

  // Every request in flight already owns a buffer slot, so overflow cannot happen.
  assign imem_req_valid = rst_n && ((outstanding + fifo_count) < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop        = if_valid && if_ready && !redirect_valid;
  assign push_entry = '{pc: resp_pc, instr: imem_rsp_data};

  assign if_valid = !fifo_empty;
  assign if_instr = if_valid ? head_entry.instr : '0;
  assign if_pc    = if_valid ? head_entry.pc    : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        // A response landing in the redirect cycle is itself discarded here.
        drop_cnt <= imem_rsp_valid ? (outstanding - ONE_C) : outstanding;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - ONE_C;
          end else begin
            resp_pc <= resp_pc + PC_STEP;
          end
        end
      end

      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with an in-order memory model.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_txn_t;

  mem_txn_t     mem_q[$];
  fetch_entry_t sb_q[$];
  logic [63:0]  acc_log[$];
  logic [63:0]  pop_log[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          fcnt = 0;
  int          drop = 0;
  int          rst_cycles = 0;
  logic [63:0] exp_fetch = RST_PC;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observe the current cycle, update the model, advance one clock, drive memory.
  task automatic cycle();
    logic exp_req;
    logic rv;
    logic rsp;
    logic acc;
    logic pop;
    int   due;
    #1;
    if (!rst_n) begin
      check_val("rst_req_valid", imem_req_valid, 1'b0);
      if (rst_cycles > 0) begin
        check_val("rst_if_valid", if_valid, 1'b0);
        check_val("rst_if_instr", if_instr, 32'h0);
        check_val("rst_if_pc", if_pc, 64'h0);
      end
      rst_cycles++;
      mem_q.delete();
      sb_q.delete();
      acc_log.delete();
      pop_log.delete();
      fcnt      = 0;
      drop      = 0;
      last_due  = 0;
      exp_fetch = RST_PC;
    end else begin
      rst_cycles = 0;
      rv  = redirect_valid;
      rsp = imem_rsp_valid;
      exp_req = ((mem_q.size() + int'(rsp) + fcnt) < DEPTH) && !rv;
      check_val("req_valid", imem_req_valid, exp_req);
      if (imem_req_valid) check_val("req_addr", imem_req_addr, exp_fetch);
      check_val("if_valid", if_valid, fcnt != 0);
      if (fcnt == 0) begin
        check_val("idle_if_instr", if_instr, 32'h0);
        check_val("idle_if_pc", if_pc, 64'h0);
      end else if (sb_q.size() != 0) begin
        check_val("if_pc", if_pc, sb_q[0].pc);
        check_val("if_instr", if_instr, sb_q[0].instr);
      end
      acc = imem_req_valid && imem_req_ready;
      pop = if_valid && if_ready && !rv;
      if (pop) begin
        pop_log.push_back(if_pc);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        if (fcnt > 0) fcnt--;
      end
      if (rv) begin
        fcnt = 0;
        drop = mem_q.size();
        sb_q.delete();
        exp_fetch = redirect_pc & ~64'h3;
      end else if (rsp) begin
        if (drop > 0) drop--;
        else fcnt++;
      end
      if (acc) begin
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = due;
        mem_q.push_back(mem_txn_t'{addr: imem_req_addr, due: due});
        sb_q.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
        acc_log.push_back(imem_req_addr);
        exp_fetch = exp_fetch + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;

    // Basic streaming after reset release.
    do_reset(3);
    repeat (8) cycle();
    check_val("stream_acc_cnt", acc_log.size() >= 3, 1'b1);
    check_val("stream_addr0", acc_log[0], 64'h0);
    check_val("stream_addr1", acc_log[1], 64'h4);
    check_val("stream_addr2", acc_log[2], 64'h8);
    check_val("stream_pop_cnt", pop_log.size() >= 3, 1'b1);
    check_val("stream_pc0", pop_log[0], 64'h0);
    check_val("stream_pc1", pop_log[1], 64'h4);
    check_val("stream_pc2", pop_log[2], 64'h8);

    // Decode stall: exactly DEPTH requests, head held.
    do_reset(2);
    if_ready = 1'b0;
    repeat (6) cycle();
    check_val("stall_acc_cnt", acc_log.size(), 64'(DEPTH));
    check_val("stall_if_valid", if_valid, 1'b1);
    check_val("stall_if_pc", if_pc, 64'h0);
    if_ready = 1'b1;
    repeat (10) cycle();
    check_val("resume_pc0", pop_log[0], 64'h0);
    check_val("resume_pc1", pop_log[1], 64'h4);
    check_val("resume_pc2", pop_log[2], 64'h8);

    // Redirect with two requests outstanding.
    do_reset(2);
    lat = 3;
    repeat (2) cycle();
    check_val("redir_outstanding", acc_log.size(), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    repeat (15) cycle();
    check_val("redir_first_pc", pop_log[0], 64'h100);
    lat = 1;

    // Unaligned redirect landing on a response cycle.
    do_reset(2);
    repeat (3) cycle();
    n = 0;
    while (!imem_rsp_valid && n < 10) begin
      cycle();
      n++;
    end
    check_val("redir_rsp_seen", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    acc_log.delete();
    cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    repeat (8) cycle();
    check_val("align_first_addr", acc_log[0], 64'h100);
    check_val("align_first_pc", pop_log[0], 64'h100);

    // Memory back-pressure with address 0x8 pending.
    do_reset(2);
    n = 0;
    while (!(imem_req_valid && imem_req_addr == 64'h8) && n < 20) begin
      cycle();
      n++;
    end
    check_val("bp_found_addr8", imem_req_valid && imem_req_addr == 64'h8, 1'b1);
    imem_req_ready = 1'b0;
    repeat (3) begin
      check_val("bp_addr_stable", imem_req_addr, 64'h8);
      cycle();
    end
    imem_req_ready = 1'b1;
    repeat (6) cycle();

    // Reset in the middle of a stream.
    do_reset(2);
    repeat (5) cycle();
    check_val("rst_refetch_addr", acc_log[0], RST_PC);

    // Random traffic with occasional redirects.
    repeat (300) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {48'h0, 16'($urandom)};
      cycle();
    end
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the instruction buffer entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-007 The block SHALL have port imem_req_addr, output, 64 bits: fetch byte address.
REQ-008 The block SHALL have port imem_rsp_valid, input, 1 bit: response valid; one response per accepted request, in order, at least 1 cycle after acceptance.
REQ-009 The block SHALL have port imem_rsp_data, input, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: taken branch or jump from execute.
REQ-011 The block SHALL have port redirect_pc, input, 64 bits: new fetch address.
REQ-012 The block SHALL have port if_valid, output, 1 bit: instruction available to decode (register file / immediate generator).
REQ-013 The block SHALL have port if_ready, input, 1 bit: decode consumes the instruction this cycle.
REQ-014 The block SHALL have port if_instr, output, 32 bits: instruction at the buffer head.
REQ-015 The block SHALL have port if_pc, output, 64 bits: PC of if_instr.

Function
REQ-016 Registers fetch_pc, resp_pc, outstanding count and drop count SHALL be held, with fetch_pc = RESET_PC on reset.
REQ-017 imem_req_valid SHALL equal (outstanding + fifo_count < FIFO_DEPTH) AND NOT redirect_valid; imem_req_addr SHALL equal fetch_pc.
REQ-018 On imem_req_valid AND imem_req_ready, fetch_pc SHALL increment by 4 (64-bit wrap) and outstanding SHALL increment.
REQ-019 While imem_req_valid is high and ready is low, addr SHALL stay stable; the request MAY be withdrawn only in a redirect cycle.
REQ-020 On imem_rsp_valid, outstanding SHALL decrement; a simultaneous accept and response SHALL leave it unchanged.
REQ-021 For a response with drop count > 0, drop count SHALL decrement and the data SHALL be discarded.
REQ-022 For a response with drop count = 0, {resp_pc, imem_rsp_data} SHALL be pushed to the buffer and resp_pc SHALL increment by 4.
REQ-023 if_valid SHALL equal buffer not empty; a pop SHALL occur on if_valid AND if_ready.
REQ-024 if_instr/if_pc SHALL show the head entry, and SHALL be 0 when if_valid is low.
REQ-025 Push and pop in the same cycle SHALL both take effect, including when full or when holding one entry.
REQ-026 The credit rule in REQ-017 SHALL make buffer overflow impossible; a push when full SHALL be an assertion failure.
REQ-027 On redirect_valid, the buffer SHALL flush and no pop SHALL occur.
REQ-028 On redirect_valid, fetch_pc and resp_pc SHALL load {redirect_pc[63:2], 2'b00}.
REQ-029 On redirect_valid, drop count SHALL load outstanding minus 1 if imem_rsp_valid that cycle (that response discarded), else outstanding.
REQ-030 The first request at the new PC SHALL be issued the cycle after redirect; a redirect arriving while drops are pending SHALL recompute drop count per REQ-029.
REQ-031 Fetch-to-decode latency SHALL be memory latency + 1 cycle (registered buffer).

Reset
REQ-032 While rst_n = 0 at posedge: imem_req_valid 0, if_valid 0, if_instr 0, if_pc 0, buffer empty, outstanding 0, drop count 0, fetch_pc = resp_pc = RESET_PC.
REQ-033 Reset mid-operation SHALL abandon in-flight requests; the memory is reset alongside, so no stale response returns.
REQ-034 The first request (addr RESET_PC) SHALL assert in the first cycle with rst_n = 1.

Structure
REQ-035 Shared package cpu_pkg SHALL hold XLEN = 64, ILEN = 32, INSTR_BYTES = 4 and the default RESET_PC.
REQ-036 Buffer SHALL be sub-module fetch_fifo (synchronous FIFO with flush, push/pop, count, width XLEN+ILEN).

Verification
REQ-037 Reset release, imem always ready, 1-cycle response, if_ready = 1 -> addrs 0x0, 0x4, 0x8; if_pc 0x0, 0x4, 0x8 in order with matching instrs.
REQ-038 if_ready = 0 for 6 cycles -> exactly FIFO_DEPTH (2) requests issued, if_valid held, head stays pc 0x0; on release the stream resumes gap-free.
REQ-039 Redirect to 0x100 with 2 outstanding -> next 2 responses discarded, buffer empty; next if_pc = 0x100 with its instr.
REQ-040 Redirect_pc 0x103 -> fetch at 0x100; redirect coinciding with a response -> that response dropped, drop count = outstanding - 1.
REQ-041 imem_req_ready low 3 cycles with addr 0x8 -> addr stable, fetch_pc unchanged; rst_n low mid-stream -> all outputs 0, refetch from RESET_PC.
